// File: rtl/uart_phy.sv
// Byte-level 8N1 UART transceiver with valid/ready byte streams on the CPU side.
// Optional `UART_LOOPBACK_EN adds a loopback input that routes the TX line into RX.
module uart_phy #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE       = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_framing_error
`ifdef UART_LOOPBACK_EN
  ,
  input  logic       loopback
`endif
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_line  <= 1'b0;
            tx_ready <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_line  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- line muxing
  logic rx_in;

`ifdef UART_LOOPBACK_EN
  assign uart_txd = loopback ? 1'b1 : tx_line;
  assign rx_in    = loopback ? tx_line : uart_rxd;
`else
  assign uart_txd = tx_line;
  assign rx_in    = uart_rxd;
`endif

  // ---------------------------------------------------------------- RX conditioning
  logic       rx_s1;
  logic       rx_s2;
  logic [1:0] rx_fill;
  logic       rx_prev;
  logic       start_edge;

  // rx_prev stays 0 until the synchronizer holds real line samples, so a line
  // held low across reset release needs a fresh 1->0 before it counts as a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_fill <= '0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_fill <= {rx_fill[0], 1'b1};
      rx_prev <= rx_fill[1] ? rx_s2 : 1'b0;
    end
  end

  assign start_edge = rx_prev & ~rx_s2;

  // ---------------------------------------------------------------- RX FSM
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_take;

  assign rx_take = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state         <= IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      rx_overrun       <= 1'b0;
      rx_framing_error <= 1'b0;
    end else begin
      rx_overrun       <= 1'b0;
      rx_framing_error <= 1'b0;
      if (rx_take) begin
        rx_valid <= 1'b0;
      end
      case (rx_state)
        IDLE: begin
          if (start_edge) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
              rx_state <= STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
            if (!rx_s2) begin
              rx_framing_error <= 1'b1;
            end else if (!rx_valid || rx_take) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy.sv
// Scoreboard bench for uart_phy: stimulus pushes expected RX events and TX frames,
// independent monitors pop and compare when the DUT presents them.
module tb_uart_phy;

  localparam int BIT = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_framing_error;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  int checks   = 0;
  int failures = 0;

  typedef enum int {EV_BYTE, EV_OVR, EV_FE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [9:0] tx_q[$];
  logic       tx_mon_en;

  always #5 clk = ~clk;

  uart_phy #(
    .CLOCK_FREQUENCY(100_000_000),
    .BAUD_RATE      (1_000_000)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_overrun      (rx_overrun),
    .rx_framing_error(rx_framing_error)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback        (loopback)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rx_unexpected_event: got kind %0d data %0h expected none", int'(k), d);
    end else begin
      e = exp_q.pop_front();
      check("rx_event_kind", int'(k), int'(e.kind));
      check("rx_event_data", {24'd0, d}, {24'd0, e.data});
    end
  endtask

  // RX monitor: new byte, overrun pulse, framing pulse
  logic rxv_q;
  always @(negedge clk) begin
    if (!reset_n) begin
      rxv_q <= 1'b0;
    end else begin
      if (rx_valid && !rxv_q) sb_pop(EV_BYTE, rx_data);
      if (rx_overrun) sb_pop(EV_OVR, rx_data);
      if (rx_framing_error) sb_pop(EV_FE, {7'd0, rx_valid});
      rxv_q <= rx_valid;
    end
  end

  // TX monitor: samples uart_txd mid-bit for 10 bits after each falling edge
  logic       txm_busy;
  logic       txm_prev;
  int         txm_cnt;
  logic [9:0] txm_frame;
  logic [9:0] txm_exp;
  always @(negedge clk) begin
    if (!reset_n) begin
      txm_busy <= 1'b0;
      txm_prev <= 1'b1;
      txm_cnt  <= 0;
    end else begin
      txm_prev <= uart_txd;
      if (!txm_busy) begin
        if (tx_mon_en && txm_prev && !uart_txd) begin
          txm_busy <= 1'b1;
          txm_cnt  <= 1;
        end
      end else begin
        txm_cnt <= txm_cnt + 1;
        if (txm_cnt == 950) begin
          txm_busy <= 1'b0;
          if (tx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_frame: got %0h expected none", {uart_txd, txm_frame[9:1]});
          end else begin
            txm_exp = tx_q.pop_front();
            check("tx_frame_bits", {22'd0, uart_txd, txm_frame[9:1]}, {22'd0, txm_exp});
          end
        end else if (txm_cnt % 100 == 50) begin
          txm_frame <= {uart_txd, txm_frame[9:1]};
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      idle(BIT);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic consume(input logic [7:0] exp);
    check("consume_valid_before", {31'd0, rx_valid}, 32'd1);
    check("consume_data", {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("consume_valid_cleared", {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    uart_rxd  = 1'b1;
    tx_data   = '0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    tx_mon_en = 1'b1;
`ifdef UART_LOOPBACK_EN
    loopback  = 1'b0;
`endif
    idle(3);
    check("reset_uart_txd", {31'd0, uart_txd}, 32'd1);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_overrun", {31'd0, rx_overrun}, 32'd0);
    check("reset_rx_framing_error", {31'd0, rx_framing_error}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    // TX 0xA5: ready falls next cycle, rises 1000 cycles after the handshake
    tx_q.push_back({1'b1, 8'hA5, 1'b0});
    tx_send(8'hA5);
    check("tx_ready_fall", {31'd0, tx_ready}, 32'd0);
    check("tx_start_bit", {31'd0, uart_txd}, 32'd0);
    n = 1;
    while (!tx_ready && n < 1100) begin
      @(posedge clk);
      #1;
      if (!tx_ready) n++;
    end
    check("tx_ready_rise_cycles", n, 32'd1000);
    idle(20);

    // RX 0x3C held until consumed
    push_ev(EV_BYTE, 8'h3C);
    send_rx(8'h3C, 1'b1);
    check("rx_3c_valid", {31'd0, rx_valid}, 32'd1);
    idle(200);
    consume(8'h3C);

    // false start then 0x55
    uart_rxd = 1'b0;
    idle(20);
    uart_rxd = 1'b1;
    idle(200);
    check("false_start_no_valid", {31'd0, rx_valid}, 32'd0);
    push_ev(EV_BYTE, 8'h55);
    send_rx(8'h55, 1'b1);
    idle(10);
    consume(8'h55);

    // framing error on 0x81, then 0x12
    push_ev(EV_FE, 8'h00);
    send_rx(8'h81, 1'b0);
    idle(50);
    check("framing_no_valid", {31'd0, rx_valid}, 32'd0);
    push_ev(EV_BYTE, 8'h12);
    send_rx(8'h12, 1'b1);
    idle(10);
    consume(8'h12);

    // overrun: 0x11 kept, 0x22 dropped
    push_ev(EV_BYTE, 8'h11);
    push_ev(EV_OVR, 8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    idle(20);
    check("overrun_valid_kept", {31'd0, rx_valid}, 32'd1);
    check("overrun_data_kept", {24'd0, rx_data}, 32'h11);

    // reset during TX data bit 3 (0xC3 drives 0 there) and RX data bit 4
    tx_mon_en = 1'b0;
    fork
      send_rx(8'h0F, 1'b1);
      begin
        idle(50);
        tx_send(8'hC3);
        idle(470);
        check("pre_reset_txd_low", {31'd0, uart_txd}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("midreset_uart_txd", {31'd0, uart_txd}, 32'd1);
        check("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        idle(3);
        reset_n = 1'b1;
      end
    join
    idle(300);
    check("post_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("post_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    tx_mon_en = 1'b1;

    // 0xF0 exchange after reset
    tx_q.push_back({1'b1, 8'hF0, 1'b0});
    push_ev(EV_BYTE, 8'hF0);
    fork
      tx_send(8'hF0);
      send_rx(8'hF0, 1'b1);
    join
    idle(100);
    consume(8'hF0);
    check("f0_tx_ready", {31'd0, tx_ready}, 32'd1);

`ifdef UART_LOOPBACK_EN
    loopback  = 1'b1;
    tx_mon_en = 1'b0;
    push_ev(EV_BYTE, 8'hF0);
    tx_send(8'hF0);
    idle(500);
    check("loopback_txd_forced", {31'd0, uart_txd}, 32'd1);
    idle(600);
    consume(8'hF0);
    loopback  = 1'b0;
    tx_mon_en = 1'b1;
`endif

    idle(20);
    check("rx_scoreboard_empty", exp_q.size(), 32'd0);
    check("tx_scoreboard_empty", tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
